e203_reset_seq: RTL and testbench

// Reset sequencer after the core reset synchronizer. Releases N_DOM reset domains in fixed

---
 rtl/e203_reset_seq.sv | 177 +++++++++++++++++
 tb/tb_e203_reset_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/e203_reset_seq.sv
// ----------------------------------------------------------------------------
// e203_reset_seq
// Reset sequencer that follows the core reset synchronizer. It holds every
// reset domain for HOLD_CYC cycles, then releases domain 0 (always-on/CLINT),
// memories, core and peripherals in order, STEP_CYC cycles apart. Warm-reset
// requests from the watchdog, debug module and software are merged into one
// re-sequence. test_mode hands the domain resets straight to rst_n for scan.
//
// Optional feature macro: E203_RESET_SEQ_CAUSE_EN
//   defined   : rst_cause records the winning requester (01 wdg, 10 dbg, 11 sw),
//               cleared to 00 (power-on) only by rst_n.
//   undefined : rst_cause is tied to 2'b00.
// ----------------------------------------------------------------------------
module e203_reset_seq #(
   parameter int N_DOM    = 4,
   parameter int HOLD_CYC = 16,
   parameter int STEP_CYC = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             test_mode,
   input  logic             wdg_rst_req,
   input  logic             dbg_rst_req,
   input  logic             sw_rst_req,
   output logic [N_DOM-1:0] dom_rst_n,
   output logic             rst_ack,
   output logic             seq_busy,
   output logic             seq_done,
   output logic [1:0]       rst_cause
);

   localparam int MAX_CYC = (HOLD_CYC > STEP_CYC) ? HOLD_CYC : STEP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam int IDX_W   = $clog2(N_DOM) + 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'b00,
      ST_RELEASE = 2'b01,
      ST_RUN     = 2'b10
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic [IDX_W-1:0]  idx_r;
   logic [IDX_W-1:0]  idx_nxt_s;
   logic [N_DOM-1:0]  dom_r;
   logic [N_DOM-1:0]  dom_nxt_s;
   logic              ack_r;
   logic              ack_nxt_s;
   logic              any_req_s;
   logic              accept_s;

   // In RUN any requester is taken; while sequencing only the watchdog may restart.
   assign any_req_s = wdg_rst_req | dbg_rst_req | sw_rst_req;
   assign accept_s  = (state_r == ST_RUN) ? any_req_s : wdg_rst_req;

   // Next-state logic: an accepted request always wins over the release schedule.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      idx_nxt_s   = idx_r;
      dom_nxt_s   = dom_r;
      ack_nxt_s   = 1'b0;
      if (accept_s) begin
         state_nxt_s = ST_HOLD;
         cnt_nxt_s   = {CNT_W{1'b0}};
         idx_nxt_s   = {IDX_W{1'b0}};
         dom_nxt_s   = {N_DOM{1'b0}};
         ack_nxt_s   = 1'b1;
      end else begin
         case (state_r)
            ST_HOLD: begin
               if (cnt_r == HOLD_LAST) begin
                  dom_nxt_s[0] = 1'b1;
                  cnt_nxt_s    = {CNT_W{1'b0}};
                  idx_nxt_s    = IDX_W'(1);
                  state_nxt_s  = (N_DOM == 1) ? ST_RUN : ST_RELEASE;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (cnt_r == STEP_LAST) begin
                  for (int i = 0; i < N_DOM; i++) begin
                     dom_nxt_s[i] = dom_r[i] | (idx_r == IDX_W'(i));
                  end
                  cnt_nxt_s   = {CNT_W{1'b0}};
                  idx_nxt_s   = idx_r + IDX_W'(1);
                  state_nxt_s = (idx_r == IDX_LAST) ? ST_RUN : ST_RELEASE;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_W'(1);
               end
            end
            ST_RUN: begin
               state_nxt_s = ST_RUN;
            end
            default: begin
               state_nxt_s = ST_HOLD;
               cnt_nxt_s   = {CNT_W{1'b0}};
               idx_nxt_s   = {IDX_W{1'b0}};
               dom_nxt_s   = {N_DOM{1'b0}};
            end
         endcase
      end
   end

   // Sequencer state and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_HOLD;
         cnt_r   <= {CNT_W{1'b0}};
         idx_r   <= {IDX_W{1'b0}};
         dom_r   <= {N_DOM{1'b0}};
         ack_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         idx_r   <= idx_nxt_s;
         dom_r   <= dom_nxt_s;
         ack_r   <= ack_nxt_s;
      end
   end

   // Scan bypass drives every domain from rst_n; status outputs stay FSM-driven.
   assign dom_rst_n = test_mode ? {N_DOM{rst_n}} : dom_r;
   assign rst_ack   = ack_r;
   assign seq_busy  = (state_r == ST_HOLD) || (state_r == ST_RELEASE);
   assign seq_done  = (state_r == ST_RUN);

`ifdef E203_RESET_SEQ_CAUSE_EN
   logic [1:0] cause_r;
   logic [1:0] cause_nxt_s;

   // Priority encode the winning requester: watchdog, then debug, then software.
   function automatic logic [1:0] cause_code(input logic wdg, input logic dbg);
      logic [1:0] code;
      if (wdg) begin
         code = 2'b01;
      end else if (dbg) begin
         code = 2'b10;
      end else begin
         code = 2'b11;
      end
      return code;
   endfunction

   // Record the cause only on the cycle a request is accepted.
   always_comb begin
      cause_nxt_s = cause_r;
      if (accept_s) begin
         cause_nxt_s = cause_code(wdg_rst_req, dbg_rst_req);
      end else begin
         cause_nxt_s = cause_r;
      end
   end

   // Cause register, cleared to power-on only by rst_n.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cause_r <= 2'b00;
      end else begin
         cause_r <= cause_nxt_s;
      end
   end

   assign rst_cause = cause_r;
`else
   assign rst_cause = 2'b00;
`endif

endmodule

// File: tb/tb_e203_reset_seq.sv
// ----------------------------------------------------------------------------
// Self-checking bench for e203_reset_seq. Expected checkpoints are derived from
// the release schedule (edge HOLD-1+i*STEP after the first HOLD edge) and
// queued in cycle order when stimulus is driven; a negedge monitor pops and
// compares them. A second instance covers the N_DOM=1, HOLD=1, STEP=1 corner.
// ----------------------------------------------------------------------------
module tb_e203_reset_seq;

   localparam int N    = 4;
   localparam int HOLD = 16;
   localparam int STEP = 8;
`ifdef E203_RESET_SEQ_CAUSE_EN
   localparam logic CAUSE_ON = 1'b1;
`else
   localparam logic CAUSE_ON = 1'b0;
`endif

   typedef struct {
      int         cyc;
      logic [3:0] dom;
      logic       ack;
      logic       busy;
      logic       done;
      logic [1:0] cause;
   } chk_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       test_mode = 1'b0;
   logic       wdg = 1'b0;
   logic       dbg = 1'b0;
   logic       sw = 1'b0;
   logic [3:0] dom_rst_n;
   logic       rst_ack;
   logic       seq_busy;
   logic       seq_done;
   logic [1:0] rst_cause;

   logic       rst1_n = 1'b0;
   logic [0:0] dom1;
   logic       ack1;
   logic       busy1;
   logic       done1;
   logic [1:0] cause1;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   chk_t sb_q[$];

   e203_reset_seq #(.N_DOM(N), .HOLD_CYC(HOLD), .STEP_CYC(STEP)) u_dut (
      .clk(clk), .rst_n(rst_n), .test_mode(test_mode),
      .wdg_rst_req(wdg), .dbg_rst_req(dbg), .sw_rst_req(sw),
      .dom_rst_n(dom_rst_n), .rst_ack(rst_ack), .seq_busy(seq_busy),
      .seq_done(seq_done), .rst_cause(rst_cause)
   );

   e203_reset_seq #(.N_DOM(1), .HOLD_CYC(1), .STEP_CYC(1)) u_dut1 (
      .clk(clk), .rst_n(rst1_n), .test_mode(1'b0),
      .wdg_rst_req(1'b0), .dbg_rst_req(1'b0), .sw_rst_req(1'b0),
      .dom_rst_n(dom1), .rst_ack(ack1), .seq_busy(busy1),
      .seq_done(done1), .rst_cause(cause1)
   );

   always #5 clk = ~clk;

   // Edge counter: after the Nth rising edge cyc == N.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [1:0] ec(input logic [1:0] c);
      return c & {2{CAUSE_ON}};
   endfunction

   // Expected outputs after edge e for a sequence whose first HOLD edge is s.
   function automatic chk_t mk(input int e, input int s, input logic ackf, input logic [1:0] c);
      chk_t p;
      p.cyc = e;
      for (int i = 0; i < N; i++) p.dom[i] = (e >= s + HOLD - 1 + i * STEP);
      p.done  = (e >= s + HOLD - 1 + (N - 1) * STEP);
      p.busy  = !p.done;
      p.ack   = (e == s - 1) ? ackf : 1'b0;
      p.cause = ec(c);
      return p;
   endfunction

   task automatic sb_push(input chk_t p);
      int k = 0;
      while (k < sb_q.size() && sb_q[k].cyc <= p.cyc) k++;
      sb_q.insert(k, p);
   endtask

   task automatic expect_seq(input int s, input logic ackf, input logic [1:0] c, input int stop);
      if (s - 1 < stop) sb_push(mk(s - 1, s, ackf, c));
      for (int i = 0; i < N; i++) begin
         int r = s + HOLD - 1 + i * STEP;
         if (r - 1 < stop) sb_push(mk(r - 1, s, ackf, c));
         if (r < stop) sb_push(mk(r, s, ackf, c));
      end
   endtask

   task automatic wait_to(input int e);
      while (cyc < e) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Scoreboard monitor: compare every checkpoint due at this edge.
   always @(negedge clk) begin : mon
      chk_t p;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         p = sb_q.pop_front();
         if (p.cyc < cyc) begin
            chk("stale_checkpoint", 32'(cyc), 32'(p.cyc));
         end else begin
            chk("dom_rst_n", 32'(dom_rst_n), 32'(p.dom));
            chk("rst_ack",   32'(rst_ack),   32'(p.ack));
            chk("seq_busy",  32'(seq_busy),  32'(p.busy));
            chk("seq_done",  32'(seq_done),  32'(p.done));
            chk("rst_cause", 32'(rst_cause), 32'(p.cause));
         end
      end
   end

   initial begin
      // 1: power-on release 15/23/31/39 after edge 0 (= edge 4)
      wait_to(3);
      rst_n  = 1'b1;
      rst1_n = 1'b1;
      expect_seq(4, 1'b0, 2'b00, 1000000);
      chk("dom1_reset", 32'(dom1), 32'd0);
      chk("busy1_reset", 32'(busy1), 32'd1);
      wait_to(4);
      chk("dom1_edge0", 32'(dom1), 32'd1);
      chk("done1_edge0", 32'(done1), 32'd1);
      chk("busy1_edge0", 32'(busy1), 32'd0);
      chk("ack1_idle", 32'(ack1), 32'd0);
      chk("cause1_idle", 32'(cause1), 32'd0);

      // 2: software pulse in RUN, accepted on edge 46
      wait_to(45);
      expect_seq(47, 1'b1, 2'b11, 1000000);
      sw = 1'b1;
      wait_to(46);
      sw = 1'b0;

      // 3: all three requests together, watchdog wins, single ack on edge 89
      wait_to(88);
      expect_seq(90, 1'b1, 2'b01, 1000000);
      wdg = 1'b1; dbg = 1'b1; sw = 1'b1;
      wait_to(89);
      wdg = 1'b0; dbg = 1'b0; sw = 1'b0;

      // 4a: software pulse at idx=2 ignored
      wait_to(115);
      sb_push(mk(116, 90, 1'b1, 2'b01));
      sw = 1'b1;
      wait_to(116);
      sw = 1'b0;

      // 4b: new sequence, then watchdog at idx=2 restarts it
      wait_to(131);
      expect_seq(133, 1'b1, 2'b11, 159);
      sb_push(mk(158, 133, 1'b1, 2'b11));
      sw = 1'b1;
      wait_to(132);
      sw = 1'b0;
      wait_to(158);
      expect_seq(160, 1'b1, 2'b01, 186);
      wdg = 1'b1;
      wait_to(159);
      wdg = 1'b0;

      // 5: rst_n low mid-RELEASE clears domains and cause
      wait_to(185);
      sb_push(mk(186, 189, 1'b0, 2'b00));
      sb_push(mk(187, 189, 1'b0, 2'b00));
      rst_n = 1'b0;
      wait_to(188);
      rst_n = 1'b1;
      expect_seq(189, 1'b0, 2'b00, 1000000);

      // 6: test_mode bypass follows rst_n within the cycle
      wait_to(230);
      test_mode = 1'b1;
      #1 chk("tm_dom_hi", 32'(dom_rst_n), 32'hF);
      rst_n = 1'b0;
      #1 chk("tm_dom_lo", 32'(dom_rst_n), 32'h0);
      wait_to(231);
      chk("tm_busy", 32'(seq_busy), 32'd1);
      chk("tm_done", 32'(seq_done), 32'd0);
      chk("tm_ack", 32'(rst_ack), 32'd0);
      wait_to(232);
      rst_n = 1'b1;
      #1 chk("tm_dom_rise", 32'(dom_rst_n), 32'hF);
      test_mode = 1'b0;
      #1 chk("tm_off_dom", 32'(dom_rst_n), 32'h0);
      expect_seq(233, 1'b0, 2'b00, 1000000);

      wait_to(275);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

endmodule
